// File: rtl/exmem_pkg.sv
// Shared encodings and control-bundle bit positions for the
// ID/EX, EX/MEM and MEM/WB pipeline registers.
package exmem_pkg;

   typedef enum logic [1:0] {
      MEM_WORD = 2'b00,
      MEM_HALF = 2'b01,
      MEM_BYTE = 2'b10
   } mem_size_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int CTL_REGWRITE = 0;
   localparam int CTL_MEMREAD  = 1;
   localparam int CTL_MEMWRITE = 2;
   localparam int CTL_MEMTOREG = 3;
   localparam int CTL_BRANCH   = 4;
   localparam int CTL_BRANCHNE = 5;
   localparam int CTL_W        = 6;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async active-low clear,
// stall holds, flush loads zero (flush beats stall).
module pipe_field_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (flush)
         q <= '0;
      else if (!stall)
         q <= d;
   end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall/flush and branch resolve.
// Optional stall counter: define EXMEM_STALL_CNT_EN.
module ex_mem_pipe_reg
   import exmem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  Valid_in,
   input  logic [DATA_W-1:0]     ALUResult_in,
   input  logic                  Zero_in,
   input  logic [DATA_W-1:0]     WriteData_in,
   input  logic [REG_ADDR_W-1:0] WriteReg_in,
   input  logic [DATA_W-1:0]     PCPlus4_in,
   input  logic [DATA_W-1:0]     BranchTarget_in,
   input  logic                  RegWrite_in,
   input  logic                  MemRead_in,
   input  logic                  MemWrite_in,
   input  logic                  MemToReg_in,
   input  logic                  Branch_in,
   input  logic                  BranchNe_in,
   input  logic [1:0]            MemSize_in,
`ifdef EXMEM_STALL_CNT_EN
   input  logic                  StallCountClr,
   output logic [31:0]           StallCount_out,
`endif
   output logic                  Valid_out,
   output logic [DATA_W-1:0]     ALUResult_out,
   output logic                  Zero_out,
   output logic [DATA_W-1:0]     WriteData_out,
   output logic [REG_ADDR_W-1:0] WriteReg_out,
   output logic [DATA_W-1:0]     PCPlus4_out,
   output logic [DATA_W-1:0]     BranchTarget_out,
   output logic                  RegWrite_out,
   output logic                  MemRead_out,
   output logic                  MemWrite_out,
   output logic                  MemToReg_out,
   output logic                  Branch_out,
   output logic                  BranchNe_out,
   output logic [1:0]            MemSize_out,
   output logic                  BranchTaken_out
);

   localparam int DW = 4*DATA_W + REG_ADDR_W + 3;

   logic [DW-1:0]  d_in;
   logic [DW-1:0]  d_q;
   logic [CTL_W:0] c_in;
   logic [CTL_W:0] c_q;
   logic           wr_nz;

   assign d_in = {ALUResult_in, Zero_in, WriteData_in,
                  WriteReg_in, PCPlus4_in,
                  BranchTarget_in, MemSize_in};

   assign {ALUResult_out, Zero_out, WriteData_out,
           WriteReg_out, PCPlus4_out,
           BranchTarget_out, MemSize_out} = d_q;

   assign wr_nz = (WriteReg_in != REG_ADDR_W'(REG_ZERO));

   // Non-valid entries never write; read wins an illegal rd+wr.
   always_comb begin
      c_in = '0;
      c_in[CTL_W]        = Valid_in;
      c_in[CTL_REGWRITE] = Valid_in & RegWrite_in & wr_nz;
      c_in[CTL_MEMREAD]  = Valid_in & MemRead_in;
      c_in[CTL_MEMWRITE] = Valid_in & MemWrite_in & ~MemRead_in;
      c_in[CTL_MEMTOREG] = Valid_in & MemToReg_in;
      c_in[CTL_BRANCH]   = Valid_in & Branch_in;
      c_in[CTL_BRANCHNE] = Valid_in & BranchNe_in;
   end

   pipe_field_reg #(.W(DW)) u_data (
      .clk   (Clk),
      .rst_n (Rst),
      .stall (Stall),
      .flush (Flush),
      .d     (d_in),
      .q     (d_q)
   );

   pipe_field_reg #(.W(CTL_W+1)) u_ctl (
      .clk   (Clk),
      .rst_n (Rst),
      .stall (Stall),
      .flush (Flush),
      .d     (c_in),
      .q     (c_q)
   );

   assign Valid_out    = c_q[CTL_W];
   assign RegWrite_out = c_q[CTL_REGWRITE];
   assign MemRead_out  = c_q[CTL_MEMREAD];
   assign MemWrite_out = c_q[CTL_MEMWRITE];
   assign MemToReg_out = c_q[CTL_MEMTOREG];
   assign Branch_out   = c_q[CTL_BRANCH];
   assign BranchNe_out = c_q[CTL_BRANCHNE];

   assign BranchTaken_out = Valid_out & Branch_out &
                            (BranchNe_out ? ~Zero_out : Zero_out);

`ifdef EXMEM_STALL_CNT_EN
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         StallCount_out <= '0;
      else if (StallCountClr)
         StallCount_out <= '0;
      else if (Stall && !Flush && (StallCount_out != 32'hFFFF_FFFF))
         StallCount_out <= StallCount_out + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: vector table plus
// hand sequences, expected values queued and checked per cycle.
module tb_ex_mem_pipe_reg;

   typedef struct packed {
      logic        v;
      logic [31:0] alu;
      logic        z;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [31:0] pc4;
      logic [31:0] bt;
      logic [5:0]  ctl;
      logic [1:0]  ms;
   } in_t;

   typedef struct packed {
      logic        v;
      logic [31:0] alu;
      logic        z;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [31:0] pc4;
      logic [31:0] bt;
      logic [5:0]  ctl;
      logic [1:0]  ms;
      logic        tk;
   } exp_t;

   typedef struct packed {
      in_t        i;
      logic       ev;
      logic [5:0] ectl;
      logic       etk;
   } vec_t;

   logic        Clk = 0;
   logic        Rst = 0;
   logic        Stall = 0;
   logic        Flush = 0;
   logic        Valid_in = 0;
   logic [31:0] ALUResult_in = 0;
   logic        Zero_in = 0;
   logic [31:0] WriteData_in = 0;
   logic [4:0]  WriteReg_in = 0;
   logic [31:0] PCPlus4_in = 0;
   logic [31:0] BranchTarget_in = 0;
   logic        RegWrite_in = 0;
   logic        MemRead_in = 0;
   logic        MemWrite_in = 0;
   logic        MemToReg_in = 0;
   logic        Branch_in = 0;
   logic        BranchNe_in = 0;
   logic [1:0]  MemSize_in = 0;
   logic        Valid_out;
   logic [31:0] ALUResult_out;
   logic        Zero_out;
   logic [31:0] WriteData_out;
   logic [4:0]  WriteReg_out;
   logic [31:0] PCPlus4_out;
   logic [31:0] BranchTarget_out;
   logic        RegWrite_out;
   logic        MemRead_out;
   logic        MemWrite_out;
   logic        MemToReg_out;
   logic        Branch_out;
   logic        BranchNe_out;
   logic [1:0]  MemSize_out;
   logic        BranchTaken_out;
`ifdef EXMEM_STALL_CNT_EN
   logic        StallCountClr = 0;
   logic [31:0] StallCount_out;
`endif

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   vec_t tbl[10];

   always #5 Clk = ~Clk;

   ex_mem_pipe_reg dut (
      .Clk              (Clk),
      .Rst              (Rst),
      .Stall            (Stall),
      .Flush            (Flush),
      .Valid_in         (Valid_in),
      .ALUResult_in     (ALUResult_in),
      .Zero_in          (Zero_in),
      .WriteData_in     (WriteData_in),
      .WriteReg_in      (WriteReg_in),
      .PCPlus4_in       (PCPlus4_in),
      .BranchTarget_in  (BranchTarget_in),
      .RegWrite_in      (RegWrite_in),
      .MemRead_in       (MemRead_in),
      .MemWrite_in      (MemWrite_in),
      .MemToReg_in      (MemToReg_in),
      .Branch_in        (Branch_in),
      .BranchNe_in      (BranchNe_in),
      .MemSize_in       (MemSize_in),
`ifdef EXMEM_STALL_CNT_EN
      .StallCountClr    (StallCountClr),
      .StallCount_out   (StallCount_out),
`endif
      .Valid_out        (Valid_out),
      .ALUResult_out    (ALUResult_out),
      .Zero_out         (Zero_out),
      .WriteData_out    (WriteData_out),
      .WriteReg_out     (WriteReg_out),
      .PCPlus4_out      (PCPlus4_out),
      .BranchTarget_out (BranchTarget_out),
      .RegWrite_out     (RegWrite_out),
      .MemRead_out      (MemRead_out),
      .MemWrite_out     (MemWrite_out),
      .MemToReg_out     (MemToReg_out),
      .Branch_out       (Branch_out),
      .BranchNe_out     (BranchNe_out),
      .MemSize_out      (MemSize_out),
      .BranchTaken_out  (BranchTaken_out)
   );

   // ctl order {bne, br, m2r, mw, mr, rw}
   function automatic in_t mk(logic v, logic [31:0] alu, logic z,
                              logic [4:0] wr, logic [5:0] ctl,
                              logic [1:0] ms);
      in_t r;
      r.v   = v;
      r.alu = alu;
      r.z   = z;
      r.wd  = ~alu;
      r.wr  = wr;
      r.pc4 = alu + 32'd4;
      r.bt  = {alu[15:0], 16'h0040};
      r.ctl = ctl;
      r.ms  = ms;
      return r;
   endfunction

   function automatic exp_t ld_exp(in_t i, logic ev,
                                   logic [5:0] ectl, logic etk);
      exp_t e;
      e.v   = ev;
      e.alu = i.alu;
      e.z   = i.z;
      e.wd  = i.wd;
      e.wr  = i.wr;
      e.pc4 = i.pc4;
      e.bt  = i.bt;
      e.ctl = ectl;
      e.ms  = i.ms;
      e.tk  = etk;
      return e;
   endfunction

   task automatic drive(in_t i);
      Valid_in        = i.v;
      ALUResult_in    = i.alu;
      Zero_in         = i.z;
      WriteData_in    = i.wd;
      WriteReg_in     = i.wr;
      PCPlus4_in      = i.pc4;
      BranchTarget_in = i.bt;
      RegWrite_in     = i.ctl[0];
      MemRead_in      = i.ctl[1];
      MemWrite_in     = i.ctl[2];
      MemToReg_in     = i.ctl[3];
      Branch_in       = i.ctl[4];
      BranchNe_in     = i.ctl[5];
      MemSize_in      = i.ms;
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic compare(string tag);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s scoreboard empty got=0 exp=1", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".valid"}, 32'(Valid_out), 32'(e.v));
      chk({tag, ".alu"}, ALUResult_out, e.alu);
      chk({tag, ".zero"}, 32'(Zero_out), 32'(e.z));
      chk({tag, ".wdata"}, WriteData_out, e.wd);
      chk({tag, ".wreg"}, 32'(WriteReg_out), 32'(e.wr));
      chk({tag, ".pc4"}, PCPlus4_out, e.pc4);
      chk({tag, ".btgt"}, BranchTarget_out, e.bt);
      chk({tag, ".ctl"},
          32'({BranchNe_out, Branch_out, MemToReg_out,
               MemWrite_out, MemRead_out, RegWrite_out}),
          32'(e.ctl));
      chk({tag, ".msize"}, 32'(MemSize_out), 32'(e.ms));
      chk({tag, ".taken"}, 32'(BranchTaken_out), 32'(e.tk));
   endtask

   task automatic step(string tag);
      @(posedge Clk);
      #1;
      compare(tag);
   endtask

   in_t  cur;
   exp_t held;

   initial begin
      tbl[0] = '{mk(1, 32'h0000_1111, 0, 5'd8,  6'b000001, 2'b00), 1, 6'b000001, 0};
      tbl[1] = '{mk(1, 32'h0000_2222, 0, 5'd0,  6'b000001, 2'b00), 1, 6'b000000, 0};
      tbl[2] = '{mk(1, 32'h0000_3333, 0, 5'd31, 6'b000001, 2'b01), 1, 6'b000001, 0};
      tbl[3] = '{mk(1, 32'h0000_4444, 0, 5'd4,  6'b000110, 2'b10), 1, 6'b000010, 0};
      tbl[4] = '{mk(1, 32'h0000_5555, 1, 5'd0,  6'b010000, 2'b00), 1, 6'b010000, 1};
      tbl[5] = '{mk(1, 32'h0000_6666, 1, 5'd0,  6'b110000, 2'b00), 1, 6'b110000, 0};
      tbl[6] = '{mk(1, 32'h0000_7777, 0, 5'd0,  6'b110000, 2'b00), 1, 6'b110000, 1};
      tbl[7] = '{mk(0, 32'h0000_8888, 1, 5'd3,  6'b010001, 2'b00), 0, 6'b000000, 0};
      tbl[8] = '{mk(1, 32'hCAFE_0009, 0, 5'd5,  6'b001011, 2'b10), 1, 6'b001011, 0};
      tbl[9] = '{mk(1, 32'h0000_AAAA, 0, 5'd0,  6'b010000, 2'b00), 1, 6'b010000, 0};

      // reset held with random inputs
      drive(mk(1, $urandom, 1, 5'd9, 6'b010111, 2'b01));
      repeat (3) @(posedge Clk);
      #1;
      sb.push_back('0);
      compare("reset");

      @(negedge Clk);
      Rst = 1;
      cur = mk(1, 32'h0000_0010, 0, 5'd2, 6'b000000, 2'b00);
      drive(cur);
      sb.push_back(ld_exp(cur, 1, 6'b000000, 0));
      step("first_load");

      for (int k = 0; k < 10; k++) begin
         @(negedge Clk);
         drive(tbl[k].i);
         sb.push_back(ld_exp(tbl[k].i, tbl[k].ev, tbl[k].ectl, tbl[k].etk));
         step($sformatf("vec%0d", k));
      end

      // stall holds a valid entry for three cycles
      @(negedge Clk);
      cur = mk(1, 32'hDEAD_BEEF, 0, 5'd8, 6'b000001, 2'b00);
      drive(cur);
      held = ld_exp(cur, 1, 6'b000001, 0);
      sb.push_back(held);
      step("stall_load");
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         Stall = 1;
         drive(mk(1, 32'h1, 1, 5'd1, 6'b010110, 2'b11));
         sb.push_back(held);
         step($sformatf("stall%0d", k));
      end

      // flush wins over stall
      @(negedge Clk);
      Flush = 1;
      sb.push_back('0);
      step("flush_stall");
      @(negedge Clk);
      Flush = 0;
      Stall = 0;

      // async reset during a stall loses the entry
      cur = mk(1, 32'h1234_5678, 0, 5'd7, 6'b001001, 2'b00);
      drive(cur);
      sb.push_back(ld_exp(cur, 1, 6'b001001, 0));
      step("pre_rst_load");
      @(negedge Clk);
      Stall = 1;
      #2;
      Rst = 0;
      #1;
      sb.push_back('0);
      compare("async_rst");
      @(negedge Clk);
      Rst = 1;
      Stall = 0;

`ifdef EXMEM_STALL_CNT_EN
      StallCountClr = 1;
      @(negedge Clk);
      StallCountClr = 0;
      chk("cnt_clr0", StallCount_out, 32'd0);
      for (int k = 0; k < 5; k++) begin
         Stall = 1;
         Flush = (k == 2);
         @(negedge Clk);
      end
      Flush = 0;
      Stall = 0;
      chk("cnt_four", StallCount_out, 32'd4);
      Stall = 1;
      StallCountClr = 1;
      @(negedge Clk);
      Stall = 0;
      StallCountClr = 0;
      chk("cnt_clr_prio", StallCount_out, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=done");
      $fatal(1);
   end

endmodule
